// File: rtl/tetris_pkg.sv
// Shared Tetris piece definitions: type encoding, rotation-0 shapes, LFSR taps
// and the clockwise rotate used by the spawner.
package tetris_pkg;

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_O = 3'd1;
    localparam logic [2:0] TYPE_T = 3'd2;
    localparam logic [2:0] TYPE_S = 3'd3;
    localparam logic [2:0] TYPE_Z = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;
    localparam logic [2:0] TYPE_L = 3'd6;

    // Feedback taps for x^16+x^14+x^13+x^11+1, register shifting toward bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HALT   = 2'd2
    } spawner_state_t;

    // Masks are indexed by cell number (4*row + col), so literal MSB is cell 0.
    function automatic logic [0:15] shape_mask(input logic [2:0] t);
        logic [0:15] m;
        case (t)
            TYPE_I:  m = 16'b0000_1111_0000_0000;
            TYPE_O:  m = 16'b0000_0110_0110_0000;
            TYPE_T:  m = 16'b0100_1110_0000_0000;
            TYPE_S:  m = 16'b0110_1100_0000_0000;
            TYPE_Z:  m = 16'b1100_0110_0000_0000;
            TYPE_J:  m = 16'b1000_1110_0000_0000;
            TYPE_L:  m = 16'b0010_1110_0000_0000;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] rand_type(input logic [2:0] low_bits);
        return (low_bits == 3'd7) ? TYPE_I : low_bits;
    endfunction

    // Clockwise quarter turn: new(r,c) = old(3-c, r).
    function automatic logic [0:15] rotate_cw(input logic [0:15] m);
        logic [0:15] r_m;
        r_m = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                r_m[4*r + c] = m[4*(3-c) + r];
        return r_m;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; advances one step per enabled clock, reloads SEED on reset.
module lfsr16 import tetris_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] value
);

    logic fb;
    assign fb = ^(value & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= SEED;
        else if (enable)
            value <= {value[14:0], fb};
    end

endmodule

// File: rtl/piece_spawner.sv
// Spawns falling pieces with a one-deep preview, rotates the active piece and
// freezes everything once game_over is seen.
module piece_spawner import tetris_pkg::*; #(
    parameter int          SPAWN_X   = 3,
    parameter int          SPAWN_Y   = 20,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_req,
    input  logic        rotate_req,
    input  logic        game_over,
    output logic [0:15] float,
    output logic [3:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [2:0]  cur_type,
    output logic [2:0]  next_type,
    output logic        piece_valid,
    output logic        spawn_done
);

    spawner_state_t state_q, state_d;
    logic [0:15]    float_d;
    logic [3:0]     pos_x_d;
    logic [4:0]     pos_y_d;
    logic [2:0]     cur_d, next_d;
    logic           valid_d, done_d;
    logic [1:0]     rot_q, rot_d;
    logic [15:0]    lfsr_val;
    logic           unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q != S_HALT),
        .value  (lfsr_val)
    );

    assign unused_lfsr_hi = ^lfsr_val[15:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            float       <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            cur_type    <= TYPE_I;
            next_type   <= rand_type(LFSR_SEED[2:0]);
            piece_valid <= 1'b0;
            spawn_done  <= 1'b0;
            rot_q       <= '0;
        end else begin
            state_q     <= state_d;
            float       <= float_d;
            pos_x       <= pos_x_d;
            pos_y       <= pos_y_d;
            cur_type    <= cur_d;
            next_type   <= next_d;
            piece_valid <= valid_d;
            spawn_done  <= done_d;
            rot_q       <= rot_d;
        end
    end

    // game_over beats spawn, spawn beats rotate; HALT holds everything.
    always_comb begin
        state_d = state_q;
        float_d = float;
        pos_x_d = pos_x;
        pos_y_d = pos_y;
        cur_d   = cur_type;
        next_d  = next_type;
        valid_d = piece_valid;
        done_d  = 1'b0;
        rot_d   = rot_q;
        if (state_q != S_HALT) begin
            if (game_over) begin
                state_d = S_HALT;
            end else if (spawn_req) begin
                state_d = S_ACTIVE;
                cur_d   = next_type;
                next_d  = rand_type(lfsr_val[2:0]);
                float_d = shape_mask(next_type);
                pos_x_d = 4'(SPAWN_X);
                pos_y_d = 5'(SPAWN_Y);
                rot_d   = '0;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else if (rotate_req && state_q == S_ACTIVE) begin
                float_d = rotate_cw(float);
                rot_d   = rot_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_piece_spawner.sv
// Self-checking bench for piece_spawner: directed scenarios plus random
// spawn/rotate traffic compared against a cell-coordinate reference model.
module tb_piece_spawner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_req, rotate_req, game_over;
    logic [0:15] float;
    logic [3:0]  pos_x;
    logic [4:0]  pos_y;
    logic [2:0]  cur_type, next_type;
    logic        piece_valid, spawn_done;

    int n_tests = 0;
    int n_fail  = 0;

    piece_spawner dut (
        .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .rotate_req(rotate_req),
        .game_over(game_over), .float(float), .pos_x(pos_x), .pos_y(pos_y),
        .cur_type(cur_type), .next_type(next_type), .piece_valid(piece_valid),
        .spawn_done(spawn_done)
    );

    always #5 clk = ~clk;

    // Reference model: shapes as cell lists, pieces turned by coordinates.
    int shape_cells [7][4] = '{'{4,5,6,7}, '{5,6,9,10}, '{1,4,5,6}, '{1,2,4,5},
                               '{0,1,5,6}, '{0,4,5,6}, '{2,4,5,6}};
    int poly_exps [4] = '{16, 14, 13, 11};

    bit          m_halt, m_active, m_valid, m_done;
    logic [15:0] m_lfsr;
    logic [0:15] m_float;
    int          m_px, m_py, m_cur, m_next;

    function automatic logic [0:15] m_shape(input int t);
        logic [0:15] m = '0;
        for (int k = 0; k < 4; k++) m[shape_cells[t][k]] = 1'b1;
        return m;
    endfunction

    function automatic logic [0:15] m_turn(input logic [0:15] old);
        logic [0:15] n = '0;
        for (int i = 0; i < 16; i++)
            if (old[i]) n[4*(i%4) + (3 - i/4)] = 1'b1;
        return n;
    endfunction

    function automatic int m_rand(input logic [15:0] l);
        int v = int'(l) % 8;
        return (v == 7) ? 0 : v;
    endfunction

    function automatic logic [15:0] m_lfsr_next(input logic [15:0] l);
        logic fb = 1'b0;
        for (int k = 0; k < 4; k++) fb ^= l[poly_exps[k]-1];
        return {l[14:0], fb};
    endfunction

    task automatic model_reset();
        m_halt = 0; m_active = 0; m_valid = 0; m_done = 0;
        m_lfsr = 16'hACE1; m_float = '0; m_px = 0; m_py = 0; m_cur = 0;
        m_next = m_rand(16'hACE1);
    endtask

    task automatic model_edge(input bit s, input bit r, input bit g);
        m_done = 0;
        if (!m_halt) begin
            if (g) m_halt = 1;
            else if (s) begin
                m_cur = m_next; m_next = m_rand(m_lfsr); m_float = m_shape(m_cur);
                m_px = 3; m_py = 20; m_valid = 1; m_done = 1; m_active = 1;
            end else if (r && m_active) m_float = m_turn(m_float);
            m_lfsr = m_lfsr_next(m_lfsr);
        end
    endtask

    // Apply inputs for one rising edge; sample point is 1 time unit after it.
    task automatic step(input bit s, input bit r, input bit g);
        spawn_req = s; rotate_req = r; game_over = g;
        @(posedge clk);
        model_edge(s, r, g);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spawn_req = 0; rotate_req = 0; game_over = 0;
        model_reset();
        #12;
        n_tests++;
        if (float !== 16'h0 || piece_valid !== 1'b0 || spawn_done !== 1'b0) begin
            $display("FAIL reset_outputs: float=%h valid=%b done=%b, want 0/0/0", float, piece_valid, spawn_done);
            n_fail++;
        end
        n_tests++;
        if (next_type !== 3'd1 || cur_type !== 3'd0 || dut.lfsr_val !== 16'hACE1) begin
            $display("FAIL reset_types: next=%0d cur=%0d lfsr=%h, want 1/0/ace1", next_type, cur_type, dut.lfsr_val);
            n_fail++;
        end
        @(negedge clk); rst_n = 1'b1;
        step(0, 1, 0);
        n_tests++;
        if (float !== 16'h0 || piece_valid !== 1'b0 || next_type !== 3'd1) begin
            $display("FAIL idle_after_reset: float=%h valid=%b next=%0d, want 0/0/1", float, piece_valid, next_type);
            n_fail++;
        end
    endtask

    task automatic test_first_spawn();
        logic [0:15] exp_o = '0;
        exp_o[5] = 1; exp_o[6] = 1; exp_o[9] = 1; exp_o[10] = 1;
        step(1, 0, 0);
        n_tests++;
        if (cur_type !== 3'd1 || float !== exp_o || pos_x !== 4'd3 || pos_y !== 5'd20) begin
            $display("FAIL first_spawn: cur=%0d float=%h pos=%0d,%0d, want 1/%h/3,20", cur_type, float, pos_x, pos_y, exp_o);
            n_fail++;
        end
        n_tests++;
        if (spawn_done !== 1'b1 || piece_valid !== 1'b1 || next_type !== 3'(m_next)) begin
            $display("FAIL first_spawn_flags: done=%b valid=%b next=%0d, want 1/1/%0d", spawn_done, piece_valid, next_type, m_next);
            n_fail++;
        end
        step(0, 0, 0);
        n_tests++;
        if (spawn_done !== 1'b0) begin
            $display("FAIL spawn_done_pulse: got %b want 0", spawn_done);
            n_fail++;
        end
    endtask

    task automatic test_rotate_i();
        logic [0:15] exp_h = 16'b0000_1111_0000_0000;
        logic [0:15] exp_v = 16'b0010_0010_0010_0010;
        int tries = 0;
        while (m_next != 0 && tries < 200) begin step(1, 0, 0); tries++; end
        n_tests++;
        if (m_next != 0) begin
            $display("FAIL find_i_piece: no I piece within %0d spawns", tries);
            n_fail++;
            return;
        end
        step(1, 0, 0);
        n_tests++;
        if (cur_type !== 3'd0 || float !== exp_h) begin
            $display("FAIL i_spawn: cur=%0d float=%h, want 0/%h", cur_type, float, exp_h);
            n_fail++;
        end
        step(0, 1, 0);
        n_tests++;
        if (float !== exp_v || pos_x !== 4'd3 || pos_y !== 5'd20 || spawn_done !== 1'b0) begin
            $display("FAIL i_rotate1: float=%h pos=%0d,%0d done=%b, want %h/3,20/0", float, pos_x, pos_y, spawn_done, exp_v);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) step(0, 1, 0);
        n_tests++;
        if (float !== exp_h) begin
            $display("FAIL i_rotate4: float=%h want %h", float, exp_h);
            n_fail++;
        end
    endtask

    task automatic test_spawn_rotate_same_edge();
        int want_t;
        step(0, 1, 0);
        want_t = m_next;
        step(1, 1, 0);
        n_tests++;
        if (float !== m_shape(want_t) || cur_type !== 3'(want_t) || spawn_done !== 1'b1) begin
            $display("FAIL spawn_beats_rotate: float=%h cur=%0d done=%b, want %h/%0d/1", float, cur_type, spawn_done, m_shape(want_t), want_t);
            n_fail++;
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1, 1'b0);
            if (float !== m_float || pos_x !== 4'(m_px) || pos_y !== 5'(m_py) ||
                cur_type !== 3'(m_cur) || next_type !== 3'(m_next) ||
                piece_valid !== m_valid || spawn_done !== m_done || dut.lfsr_val !== m_lfsr) begin
                if (bad < 5)
                    $display("FAIL random_traffic cycle %0d: float=%h cur=%0d next=%0d done=%b lfsr=%h, want %h/%0d/%0d/%b/%h",
                             n, float, cur_type, next_type, spawn_done, dut.lfsr_val, m_float, m_cur, m_next, m_done, m_lfsr);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_halt();
        int bad = 0;
        step(1, 0, 0);
        step(0, 1, 1);
        for (int n = 0; n < 10; n++) begin
            step(1, 1, $urandom_range(0, 1) == 1);
            if (float !== m_float || cur_type !== 3'(m_cur) || next_type !== 3'(m_next) ||
                spawn_done !== 1'b0 || dut.lfsr_val !== m_lfsr || piece_valid !== 1'b1) begin
                if (bad < 3)
                    $display("FAIL halt_frozen cycle %0d: float=%h done=%b lfsr=%h, want %h/0/%h",
                             n, float, spawn_done, dut.lfsr_val, m_float, m_lfsr);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_reset_in_halt();
        logic [0:15] exp_o = 16'b0000_0110_0110_0000;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (float !== 16'h0 || piece_valid !== 1'b0 || cur_type !== 3'd0 || next_type !== 3'd1 ||
            pos_x !== 4'd0 || pos_y !== 5'd0 || dut.lfsr_val !== 16'hACE1) begin
            $display("FAIL async_reset_in_halt: float=%h valid=%b cur=%0d next=%0d lfsr=%h, want 0/0/0/1/ace1",
                     float, piece_valid, cur_type, next_type, dut.lfsr_val);
            n_fail++;
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step(1, 0, 0);
        n_tests++;
        if (cur_type !== 3'd1 || float !== exp_o || spawn_done !== 1'b1) begin
            $display("FAIL spawn_after_reset: cur=%0d float=%h done=%b, want 1/%h/1", cur_type, float, spawn_done, exp_o);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_rotate_i();
        test_spawn_rotate_same_edge();
        test_random();
        test_halt();
        test_reset_in_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
